vga_sync_gen: RTL and testbench

640x480 @ 60 Hz VGA timing generator that sits directly upstream of every screen renderer. It consumes a pixel-rate enable strobe, runs horizontal and vertical counters, and drives sync, pixel coordinates, active-video, end-of-frame and blanking flags. Screen stages use these outputs to look up their bitmap address and palette colour.

---
 rtl/vga_sync_gen.sv | 96 +++++++++
 tb/tb_vga_sync_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-strobe driven h/v counters with decoded sync, coordinates and flags.
// Define VGA_SYNC_FRAME_CNT_EN to add the 16-bit o_frame counter port.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pix_stb,
  output logic       o_hs,
  output logic       o_vs,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_active,
  output logic       o_blanking,
  output logic       o_animate
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0] o_frame
`endif
);

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;
  logic             h_vis;
  logic             v_vis;
  logic             last_px;

  always_comb begin
    h_last  = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_last  = (v_cnt == CNT_W'(V_TOTAL - 1));
    h_vis   = (h_cnt < CNT_W'(H_ACTIVE));
    v_vis   = (v_cnt < CNT_W'(V_ACTIVE));
    last_px = (h_cnt == CNT_W'(H_ACTIVE - 1)) && (v_cnt == CNT_W'(V_ACTIVE - 1));
  end

  // Counters advance only on pixel strobes; reset dominates the strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_pix_stb) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Zero-latency decode; coordinates clamp to the last visible pixel during blanking.
  always_comb begin
    o_hs       = !((h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END)));
    o_vs       = !((v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END)));
    o_x        = h_vis ? X_W'(h_cnt) : X_W'(H_ACTIVE - 1);
    o_y        = v_vis ? v_cnt[Y_W-1:0] : Y_W'(V_ACTIVE - 1);
    o_active   = h_vis && v_vis;
    o_blanking = !(h_vis && v_vis);
    o_animate  = i_rst_n && i_pix_stb && last_px;
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame_cnt <= '0;
    end else if (o_animate) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  assign o_frame = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line timing, shrunk instance for frame timing.
// Define VGA_SYNC_FRAME_CNT_EN to also check o_frame.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [8:0] y;
    logic       act;
    logic       blank;
    logic       anim;
  } out_t;

  // Small geometry: 24 strobes per line, 15 lines, 360 strobes per frame.
  localparam int unsigned SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 2;
  localparam int unsigned SV_A = 8,  SV_F = 2, SV_S = 2, SV_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic stb;

  logic       d0_hs, d0_vs, d0_act, d0_blank, d0_anim;
  logic [9:0] d0_x;
  logic [8:0] d0_y;
  logic       d1_hs, d1_vs, d1_act, d1_blank, d1_anim;
  logic [9:0] d1_x;
  logic [8:0] d1_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] d0_frame, d1_frame;
`endif

  always #5 clk = ~clk;

  vga_sync_gen u_d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb),
    .o_hs(d0_hs), .o_vs(d0_vs), .o_x(d0_x), .o_y(d0_y),
    .o_active(d0_act), .o_blanking(d0_blank), .o_animate(d0_anim)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .o_frame(d0_frame)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B)
  ) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb),
    .o_hs(d1_hs), .o_vs(d1_vs), .o_x(d1_x), .o_y(d1_y),
    .o_active(d1_act), .o_blanking(d1_blank), .o_animate(d1_anim)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .o_frame(d1_frame)
`endif
  );

  out_t o0, o1;
  assign o0 = {d0_hs, d0_vs, d0_x, d0_y, d0_act, d0_blank, d0_anim};
  assign o1 = {d1_hs, d1_vs, d1_x, d1_y, d1_act, d1_blank, d1_anim};

  int n_cmp = 0;
  int n_err = 0;
  int mh0, mv0, mh1, mv1;
  int mf1;
  out_t q0[$];
  out_t q1[$];

  int hs0_cnt, hs0_first, act0_fall, pos0;
  int anim1_cnt, anim1_idx, vs1_cnt, idx1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("comparison %s differs", tag);
    end
  endtask

  function automatic out_t model(input int h, input int v, input bit s, input bit r,
                                 input int ha, input int hf, input int hsw,
                                 input int va, input int vf, input int vsw);
    out_t m;
    bit hv, vv;
    hv      = (h < ha);
    vv      = (v < va);
    m.hs    = !((h >= ha + hf) && (h < ha + hf + hsw));
    m.vs    = !((v >= va + vf) && (v < va + vf + vsw));
    m.x     = hv ? 10'(h) : 10'(ha - 1);
    m.y     = vv ? 9'(v) : 9'(va - 1);
    m.act   = hv && vv;
    m.blank = !(hv && vv);
    m.anim  = r && s && (h == ha - 1) && (v == va - 1);
    return m;
  endfunction

  // One clock: drive on the falling edge, check decoded outputs, then advance the model at the rising edge.
  task automatic cyc(input bit s, input bit r);
    out_t e0, e1;
    @(negedge clk);
    stb   = s;
    rst_n = r;
    q0.push_back(model(mh0, mv0, s, r, 640, 16, 96, 480, 10, 2));
    q1.push_back(model(mh1, mv1, s, r, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S));
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check("d0_outputs", 32'(o0), 32'(e0));
    check("d1_outputs", 32'(o1), 32'(e1));
    if (r && s) begin
      if (!d0_hs) begin
        hs0_cnt++;
        if (hs0_first < 0) hs0_first = pos0;
      end
      if (!d0_act && act0_fall < 0) act0_fall = pos0;
      if (!d1_vs) vs1_cnt++;
      pos0++;
    end
    if (d1_anim) begin
      anim1_cnt++;
      anim1_idx = idx1;
    end
    if (r && s) idx1++;
    if (e1.anim) mf1 = (mf1 + 1) % 65536;
    @(posedge clk);
    if (!r) begin
      mh0 = 0; mv0 = 0; mh1 = 0; mv1 = 0; mf1 = 0;
    end else if (s) begin
      if (mh0 == 799) begin mh0 = 0; mv0 = (mv0 == 524) ? 0 : mv0 + 1; end
      else mh0++;
      if (mh1 == 23) begin mh1 = 0; mv1 = (mv1 == 14) ? 0 : mv1 + 1; end
      else mh1++;
    end
  endtask

  initial begin
    int n;
    bit s;
    rst_n = 1'b0;
    stb   = 1'b0;
    mh0 = 0; mv0 = 0; mh1 = 0; mv1 = 0; mf1 = 0;
    hs0_cnt = 0; hs0_first = -1; act0_fall = -1; pos0 = 0;
    anim1_cnt = 0; anim1_idx = -1; vs1_cnt = 0; idx1 = 0;
    @(posedge clk);

    // Reset held for 5 cycles with 1-in-4 strobes running.
    for (int i = 0; i < 5; i++) cyc(i % 4 == 0, 1'b0);
    #1;
    check("rst_x", 32'(d0_x), 32'd0);
    check("rst_y", 32'(d0_y), 32'd0);
    check("rst_active", 32'(d0_act), 32'd1);
    check("rst_hs_vs", 32'({d0_hs, d0_vs}), 32'd3);

    // First strobe after release.
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    #1;
    check("first_strobe_x", 32'(d0_x), 32'd1);

    // Strobe gating at column 300.
    while (mh0 != 300) cyc(1'b1, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1);
    #1;
    check("gated_x", 32'(d0_x), 32'd300);

    // Rest of the line on the full-size instance.
    hs0_cnt = 0; hs0_first = -1; act0_fall = -1; pos0 = 300;
    do cyc(1'b1, 1'b1); while (mh0 != 0);
    #1;
    check("hs_low_strobes", 32'(hs0_cnt), 32'd96);
    check("hs_first_col", 32'(hs0_first), 32'd656);
    check("active_fall_col", 32'(act0_fall), 32'd640);
    check("wrap_x", 32'(d0_x), 32'd0);
    check("wrap_y", 32'(d0_y), 32'd1);

    // Three frames on the small instance from reset, random strobe duty.
    cyc(1'b1, 1'b0);
    anim1_cnt = 0; vs1_cnt = 0; idx1 = 0;
    n = 0;
    while (n < 3 * 360) begin
      s = ($urandom_range(0, 3) != 0);
      cyc(s, 1'b1);
      if (s) n++;
    end
    #1;
    check("anim_3frames", 32'(anim1_cnt), 32'd3);
    check("vs_low_strobes", 32'(vs1_cnt), 32'(3 * SV_S * 24));
    check("frame_wrap_xy", 32'({d1_x, d1_y}), 32'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("frame_cnt_3", 32'(d1_frame), 32'd3);
    check("frame_cnt_model", 32'(d1_frame), 32'(mf1));
`endif

    // Mid-frame reset while hsync is low on line 5.
    while (!(mv1 == 5 && mh1 == 19)) cyc(1'b1, 1'b1);
    #1;
    check("pre_reset_hs", 32'(d1_hs), 32'd0);
    cyc(1'b1, 1'b0);
    #1;
    check("mid_rst_hs", 32'(d1_hs), 32'd1);
    check("mid_rst_xy", 32'({d1_x, d1_y}), 32'd0);

    // Following frame timing is exact: one animate at strobe 7*24+15.
    anim1_cnt = 0; anim1_idx = -1; idx1 = 0;
    n = 0;
    while (n < 360) begin
      s = ($urandom_range(0, 2) != 0);
      cyc(s, 1'b1);
      if (s) n++;
    end
    #1;
    check("anim_after_rst", 32'(anim1_cnt), 32'd1);
    check("anim_position", 32'(anim1_idx), 32'd183);
    check("frame_restart_xy", 32'({d1_x, d1_y}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
